// File: rtl/pll_lock_supervisor.sv
// +-----------------------------------------------------------------------------+
// | pll_lock_supervisor: qualifies PLL lock and sequences the system reset.     |
// | Optional: define PLL_LOCK_GLITCH_FILTER_EN to ignore short lock drops in RUN.|
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module pll_lock_supervisor #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4096,
  parameter int HOLD_CYCLES   = 16,
  parameter int CNT_W         = 8
) (
  input  logic             clock_in,
  input  logic             resetb,
  input  logic             pll_locked,
  input  logic             clear_sticky,
  output logic             sys_resetb,
  output logic             ready,
  output logic             lock_lost_sticky,
  output logic [CNT_W-1:0] loss_count,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_LOST   = 3'd4
  } state_t;

  localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
  localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_MAX     = '1;

`ifdef PLL_LOCK_GLITCH_FILTER_EN
  localparam int GLITCH_CYCLES = 8;
  localparam int GLITCH_W      = $clog2(GLITCH_CYCLES + 1);
  localparam logic [GLITCH_W-1:0] GLITCH_LAST = GLITCH_W'(GLITCH_CYCLES - 1);
  logic [GLITCH_W-1:0] glitch_cnt_q, glitch_cnt_d;
`endif

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic [STABLE_W-1:0]    stable_cnt_q, stable_cnt_d;
  logic                   sys_resetb_q, sys_resetb_d;
  logic                   ready_q, ready_d;
  logic                   sticky_q, sticky_d;
  logic [CNT_W-1:0]       loss_cnt_q, loss_cnt_d;
  logic                   locked_s;
  logic                   loss_event;

  assign sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    stable_cnt_d = stable_cnt_q;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
    glitch_cnt_d = '0;
`endif
    case (state_q)
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d    = ST_WAIT;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      ST_WAIT: begin
        if (locked_s) begin
          state_d      = ST_STABLE;
          stable_cnt_d = '0;
        end
      end
      ST_STABLE: begin
        if (!locked_s) begin
          state_d      = ST_WAIT;
          stable_cnt_d = '0;
        end else if (stable_cnt_q == STABLE_LAST) begin
          state_d      = ST_RUN;
          stable_cnt_d = '0;
        end else begin
          stable_cnt_d = stable_cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
`ifdef PLL_LOCK_GLITCH_FILTER_EN
        // Only a drop lasting GLITCH_CYCLES consecutive cycles counts as loss.
        if (!locked_s) begin
          if (glitch_cnt_q == GLITCH_LAST) state_d = ST_LOST;
          else                             glitch_cnt_d = glitch_cnt_q + 1'b1;
        end
`else
        if (!locked_s) state_d = ST_LOST;
`endif
      end
      ST_LOST: begin
        state_d    = ST_HOLD;
        hold_cnt_d = '0;
      end
      default: begin
        state_d      = ST_HOLD;
        hold_cnt_d   = '0;
        stable_cnt_d = '0;
      end
    endcase
  end

  // A loss event coinciding with clear_sticky restarts the record at one event.
  always_comb begin
    loss_event   = (state_q == ST_RUN) && (state_d == ST_LOST);
    sticky_d     = sticky_q;
    loss_cnt_d   = loss_cnt_q;
    if (loss_event) begin
      sticky_d   = 1'b1;
      if (clear_sticky)              loss_cnt_d = CNT_W'(1);
      else if (loss_cnt_q != CNT_MAX) loss_cnt_d = loss_cnt_q + 1'b1;
    end else if (clear_sticky) begin
      sticky_d   = 1'b0;
      loss_cnt_d = '0;
    end
    sys_resetb_d = (state_d == ST_RUN);
    ready_d      = (state_d == ST_RUN);
  end

  always_ff @(posedge clock_in or negedge resetb) begin
    if (!resetb) begin
      sync_q       <= '0;
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      stable_cnt_q <= '0;
      sys_resetb_q <= 1'b0;
      ready_q      <= 1'b0;
      sticky_q     <= 1'b0;
      loss_cnt_q   <= '0;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
      glitch_cnt_q <= '0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      stable_cnt_q <= stable_cnt_d;
      sys_resetb_q <= sys_resetb_d;
      ready_q      <= ready_d;
      sticky_q     <= sticky_d;
      loss_cnt_q   <= loss_cnt_d;
`ifdef PLL_LOCK_GLITCH_FILTER_EN
      glitch_cnt_q <= glitch_cnt_d;
`endif
    end
  end

  assign sys_resetb       = sys_resetb_q;
  assign ready            = ready_q;
  assign lock_lost_sticky = sticky_q;
  assign loss_count       = loss_cnt_q;
  assign state_dbg        = state_q;

endmodule

`default_nettype wire
